// File: rtl/beep_rate_gen.sv
// Multi-channel beep-rate generator: per-channel 50% square wave, beep-start tick, counted bursts.
// Latency: 1 cycle from en/start to first tone cycle; no backpressure, all outputs registered.
module beep_rate_gen #(
   parameter int CLK_HZ = 50_000_000,
   parameter int NUM_CH = 4,
   parameter int RATE0  = 2,
   parameter int RATE1  = 3,
   parameter int RATE2  = 4,
   parameter int RATE3  = 8,
   parameter int CNT_W  = 27,
   parameter int BW     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      en,
   input  logic [2*NUM_CH-1:0]    rate_sel,
   input  logic [NUM_CH-1:0]      start,
   input  logic [BW*NUM_CH-1:0]   burst_len,
   output logic [NUM_CH-1:0]      tone,
   output logic [NUM_CH-1:0]      tick,
   output logic [NUM_CH-1:0]      busy,
   output logic [NUM_CH-1:0]      done
);

   localparam int     HP0    = CLK_HZ / (2 * RATE0);
   localparam int     HP1    = CLK_HZ / (2 * RATE1);
   localparam int     HP2    = CLK_HZ / (2 * RATE2);
   localparam int     HP3    = CLK_HZ / (2 * RATE3);
   localparam longint HP_LIM = longint'(1) << CNT_W;

   generate
      if (HP0 < 1 || HP1 < 1 || HP2 < 1 || HP3 < 1 ||
          longint'(HP0) >= HP_LIM || longint'(HP1) >= HP_LIM ||
          longint'(HP2) >= HP_LIM || longint'(HP3) >= HP_LIM) begin : g_bad_hp
         $error("beep_rate_gen: a half-period is below 1 or does not fit in CNT_W bits");
      end
   endgenerate

   function automatic logic [CNT_W-1:0] hp_of(input logic [1:0] sel);
      case (sel)
         2'd0:    hp_of = CNT_W'(HP0);
         2'd1:    hp_of = CNT_W'(HP1);
         2'd2:    hp_of = CNT_W'(HP2);
         default: hp_of = CNT_W'(HP3);
      endcase
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_CONT, S_BURST} state_t;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d, hp_cur;
      logic             hi_q, hi_d;
      logic [1:0]       sel_q, sel_d;
      logic [BW-1:0]    rem_q, rem_d;
      logic             tick_q, tick_d, done_q, done_d;
      logic             cnt_last, go;
      logic             en_c, start_c;
      logic [1:0]       sel_c;
      logic [BW-1:0]    len_c;

      assign en_c     = en[c];
      assign start_c  = start[c];
      assign sel_c    = rate_sel[2*c +: 2];
      assign len_c    = burst_len[BW*c +: BW];
      assign hp_cur   = hp_of(sel_q);
      assign cnt_last = (cnt_q == hp_cur - CNT_W'(1));

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            sel_q   <= '0;
            rem_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         hi_d    = hi_q;
         sel_d   = sel_q;
         rem_d   = rem_q;
         tick_d  = 1'b0;
         done_d  = 1'b0;
         go      = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (en_c) begin
                  state_d = S_CONT;
                  go      = 1'b1;
               end else if (start_c && len_c != '0) begin
                  state_d = S_BURST;
                  rem_d   = len_c;
                  go      = 1'b1;
               end
            end
            S_CONT, S_BURST: begin
               if (state_q == S_CONT && !en_c) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  hi_d    = 1'b0;
               end else if (state_q == S_BURST && en_c) begin
                  state_d = S_CONT;
                  go      = 1'b1;
               end else if (!cnt_last) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (hi_q) begin
                  cnt_d = '0;
                  hi_d  = 1'b0;
               end else if (state_q == S_BURST && rem_q == BW'(1)) begin
                  // last low cycle of the final beep: finish the burst
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  rem_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  go = 1'b1;
                  if (state_q == S_BURST) rem_d = rem_q - BW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (go) begin
            cnt_d  = '0;
            hi_d   = 1'b1;
            tick_d = 1'b1;
            sel_d  = sel_c;
         end
      end

      assign tone[c] = hi_q;
      assign tick[c] = tick_q;
      assign busy[c] = (state_q != S_IDLE);
      assign done[c] = done_q;
   end

endmodule

// File: tb/tb_beep_rate_gen.sv
// Scoreboard bench for beep_rate_gen: stimulus queues per-cycle expected outputs, a negedge monitor checks them.
module tb_beep_rate_gen;

   localparam int N  = 4;
   localparam int BW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    en, start, tone, tick, busy, done;
   logic [2*N-1:0]  rate_sel;
   logic [BW*N-1:0] burst_len;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   t;
   logic ending = 1'b0;
   logic end_seen = 1'b0;
   logic [3:0] act;
   int   hp_tab [4] = '{2, 4, 5, 10};

   typedef struct {
      int         cyc;
      int         ch;
      logic [3:0] v;   // {tone, tick, busy, done}
   } exp_t;
   exp_t sb[$];

   beep_rate_gen #(
      .CLK_HZ(1000), .NUM_CH(N), .RATE0(250), .RATE1(125), .RATE2(100), .RATE3(50),
      .CNT_W(27), .BW(BW)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .rate_sel(rate_sel), .start(start),
      .burst_len(burst_len), .tone(tone), .tick(tick), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int ch, input int tc, input logic [3:0] v);
      exp_t e;
      e.cyc = tc;
      e.ch  = ch;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic exp_beeps(input int ch, input int t0, input int hp, input int n);
      for (int k = 0; k < n; k++) begin
         int p;
         p = k % (2 * hp);
         push(ch, t0 + k, {(p < hp), (p == 0), 1'b1, 1'b0});
      end
   endtask

   task automatic exp_idle(input int ch, input int t0, input int n);
      for (int k = 0; k < n; k++) push(ch, t0 + k, 4'b0000);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            act = {tone[sb[i].ch], tick[sb[i].ch], busy[sb[i].ch], done[sb[i].ch]};
            total++;
            if (sb[i].cyc < cyc) begin
               bad++;
               $display("FAIL stale ch%0d cyc%0d: expectation %b never compared", sb[i].ch, sb[i].cyc, sb[i].v);
            end else if (act !== sb[i].v) begin
               bad++;
               $display("FAIL ch%0d cyc%0d tone/tick/busy/done: got %b want %b", sb[i].ch, sb[i].cyc, act, sb[i].v);
            end
            sb.delete(i);
         end
      end
      if (ending && !end_seen) begin
         end_seen = 1'b1;
         foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL leftover ch%0d cyc%0d: expectation %b not reached", sb[i].ch, sb[i].cyc, sb[i].v);
         end
      end
   end

   initial begin
      reset = 1'b1; en = '0; start = '0; rate_sel = '0; burst_len = '0;
      repeat (3) nxt();
      t = cyc;
      for (int ch = 0; ch < N; ch++) exp_idle(ch, t, 1);
      reset = 1'b0;
      nxt();

      // continuous ch0 at HP=2, start ignored in CONT, en dropped mid-high
      t = cyc;
      en[0] = 1'b1; rate_sel[1:0] = 2'd0;
      exp_beeps(0, t + 1, 2, 10);
      exp_idle(0, t + 11, 3);
      exp_idle(1, t + 1, 13);
      repeat (4) nxt();
      start[0] = 1'b1; burst_len[3:0] = 4'd3;
      nxt();
      start[0] = 1'b0;
      repeat (5) nxt();
      en[0] = 1'b0;
      repeat (4) nxt();

      // burst of 3 at HP=4, then back-to-back burst of 2 at HP=2
      t = cyc;
      start[1] = 1'b1; burst_len[7:4] = 4'd3; rate_sel[3:2] = 2'd1;
      exp_beeps(1, t + 1, 4, 24);
      push(1, t + 25, 4'b0001);
      nxt();
      start[1] = 1'b0;
      repeat (24) nxt();
      start[1] = 1'b1; burst_len[7:4] = 4'd2; rate_sel[3:2] = 2'd0;
      exp_beeps(1, t + 26, 2, 8);
      push(1, t + 34, 4'b0001);
      exp_idle(1, t + 35, 3);
      nxt();
      start[1] = 1'b0;
      repeat (12) nxt();

      // zero-length burst ignored
      t = cyc;
      start[2] = 1'b1; burst_len[11:8] = 4'd0;
      exp_idle(2, t + 1, 6);
      nxt();
      start[2] = 1'b0;
      repeat (6) nxt();

      // en raised mid-burst: fresh beep next cycle, no done
      t = cyc;
      start[2] = 1'b1; burst_len[11:8] = 4'd5; rate_sel[5:4] = 2'd0;
      exp_beeps(2, t + 1, 2, 6);
      nxt();
      start[2] = 1'b0;
      repeat (5) nxt();
      en[2] = 1'b1;
      exp_beeps(2, t + 7, 2, 24);
      repeat (24) nxt();
      en[2] = 1'b0;
      exp_idle(2, t + 31, 3);
      repeat (4) nxt();

      // rate change mid-high: current beep 5+5, then 10+10
      t = cyc;
      en[3] = 1'b1; rate_sel[7:6] = 2'd2;
      exp_beeps(3, t + 1, 5, 10);
      exp_beeps(3, t + 11, 10, 40);
      repeat (3) nxt();
      rate_sel[7:6] = 2'd3;
      repeat (47) nxt();
      en[3] = 1'b0;
      exp_idle(3, t + 51, 2);
      repeat (3) nxt();

      // all channels running, reset mid-beep, then restart
      t = cyc;
      en = 4'hF; rate_sel = 8'b11_10_01_00;
      for (int ch = 0; ch < N; ch++) begin
         exp_beeps(ch, t + 1, hp_tab[ch], 7);
         exp_idle(ch, t + 8, 2);
         exp_beeps(ch, t + 10, hp_tab[ch], 45);
         exp_idle(ch, t + 55, 2);
      end
      repeat (7) nxt();
      reset = 1'b1;
      repeat (2) nxt();
      reset = 1'b0;
      repeat (45) nxt();
      en = '0;
      repeat (4) nxt();

      ending = 1'b1;
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
